adc_sample_sched: RTL

ADC_SAMPLE_SCHED -- requirements
Module: adc_sample_sched

---
 rtl/adc_sample_sched.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/adc_sample_sched.sv
// rtl/adc_sample_sched.sv - periodic multi-channel ADC sweep scheduler
// A tick every TICK_CYCLES starts a sweep over the set bits of ch_mask, one conversion per channel.
module adc_sample_sched #(
  parameter int TICK_CYCLES = 96,
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 12,
  parameter int TIMEOUT     = 32,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              err_clr,
  output logic              adc_start,
  output logic [CH_W-1:0]   adc_ch,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [CH_W-1:0]   sample_ch,
  output logic [DATA_W-1:0] sample_data,
  output logic              busy,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TICK_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CONVERT, WAIT_DONE, OUTPUT} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              tick;
  logic [TMO_W-1:0]  tmo;
  logic [NUM_CH-1:0] mask_q;
  logic [CH_W-1:0]   low_ch;
  logic [CH_W-1:0]   nxt_ch;
  logic              nxt_found;
  logic              tmo_hit;
  logic              sweep_start;

  // Tick generator: held at zero while disabled so the first tick lands a full period after enable.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!enable) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_W'(TICK_CYCLES - 1));
      cnt  <= (cnt == CNT_W'(TICK_CYCLES - 1)) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Lowest set bit of the live mask, and the next set bit above adc_ch in the latched mask.
  always_comb begin
    low_ch    = '0;
    nxt_ch    = '0;
    nxt_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) low_ch = CH_W'(i);
      if (mask_q[i] && (i > int'(adc_ch))) begin
        nxt_found = 1'b1;
        nxt_ch    = CH_W'(i);
      end
    end
  end

  assign tmo_hit     = (state == WAIT_DONE) && !adc_done && (tmo == TMO_W'(TIMEOUT - 1));
  assign sweep_start = (state == IDLE) && tick && (ch_mask != '0);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      tmo          <= '0;
      mask_q       <= '0;
      adc_start    <= 1'b0;
      adc_ch       <= '0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      // Sticky flags: a set in the same cycle as err_clr wins.
      if (tick && busy)  overrun <= 1'b1;
      else if (err_clr)  overrun <= 1'b0;
      if (tmo_hit)       timeout_err <= 1'b1;
      else if (err_clr)  timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (sweep_start) begin
            mask_q    <= ch_mask;
            adc_ch    <= low_ch;
            adc_start <= 1'b1;
            busy      <= 1'b1;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          adc_start <= 1'b0;
          tmo       <= '0;
          state     <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (adc_done) begin
            sample_data  <= adc_data;
            sample_ch    <= adc_ch;
            sample_valid <= 1'b1;
            state        <= OUTPUT;
          end else if (tmo_hit) begin
            if (nxt_found) begin
              adc_ch    <= nxt_ch;
              adc_start <= 1'b1;
              state     <= CONVERT;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        OUTPUT: begin
          if (sample_ready) begin
            sample_valid <= 1'b0;
            if (nxt_found) begin
              adc_ch    <= nxt_ch;
              adc_start <= 1'b1;
              state     <= CONVERT;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
